// File: rtl/sc_level_progress_if.sv
// Level-tracking bus between the level progress producer and the level state machine.
// The slave modport is the producer side; the master modport drives the game events.
interface sc_level_progress_if #(
   parameter int LEVEL_DATAWIDTH    = 3,
   parameter int PROGRESS_DATAWIDTH = 5
);
   // Valid/ready note: every event input is a level or single-cycle pulse sampled on each
   // rising clock edge with no back-pressure; every output is valid on every cycle.
   logic                          SC_LEVEL_PROGRESS_Start_InHigh;
   logic                          SC_LEVEL_PROGRESS_Advance_InHigh;
   logic                          SC_LEVEL_PROGRESS_LevelFinished_In;
   logic                          SC_LEVEL_PROGRESS_StartCount_In;
   logic [LEVEL_DATAWIDTH-1:0]    SC_LEVEL_PROGRESS_CurrentLevel_Out;
   logic [PROGRESS_DATAWIDTH-1:0] SC_LEVEL_PROGRESS_LvlProgressCount_Out;
   logic                          SC_LEVEL_PROGRESS_Paused_Out;
   logic                          SC_LEVEL_PROGRESS_LevelUp_Out;
   logic [1:0]                    SC_LEVEL_PROGRESS_State_Out;

   modport master (
      output SC_LEVEL_PROGRESS_Start_InHigh,
      output SC_LEVEL_PROGRESS_Advance_InHigh,
      output SC_LEVEL_PROGRESS_LevelFinished_In,
      output SC_LEVEL_PROGRESS_StartCount_In,
      input  SC_LEVEL_PROGRESS_CurrentLevel_Out,
      input  SC_LEVEL_PROGRESS_LvlProgressCount_Out,
      input  SC_LEVEL_PROGRESS_Paused_Out,
      input  SC_LEVEL_PROGRESS_LevelUp_Out,
      input  SC_LEVEL_PROGRESS_State_Out
   );

   modport slave (
      input  SC_LEVEL_PROGRESS_Start_InHigh,
      input  SC_LEVEL_PROGRESS_Advance_InHigh,
      input  SC_LEVEL_PROGRESS_LevelFinished_In,
      input  SC_LEVEL_PROGRESS_StartCount_In,
      output SC_LEVEL_PROGRESS_CurrentLevel_Out,
      output SC_LEVEL_PROGRESS_LvlProgressCount_Out,
      output SC_LEVEL_PROGRESS_Paused_Out,
      output SC_LEVEL_PROGRESS_LevelUp_Out,
      output SC_LEVEL_PROGRESS_State_Out
   );
endinterface

// File: rtl/sc_level_progress.sv
// Tracks the current level and per-level advance count, with a timed pause between levels.
// All outputs come from registers or from the registered state only.
module sc_level_progress #(
   parameter int LEVEL_DATAWIDTH    = 3,
   parameter int PROGRESS_DATAWIDTH = 5,
   parameter int PROGRESS_TARGET    = 12,
   parameter int MAX_LEVEL          = 3,
   parameter int PAUSE_CYCLES       = 50000000,
   parameter int PAUSE_DATAWIDTH    = 26
) (
   input logic SC_LEVEL_PROGRESS_CLOCK_50,
   input logic SC_LEVEL_PROGRESS_RESET_InHigh,
   sc_level_progress_if.slave levelBus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [PROGRESS_DATAWIDTH-1:0] targetCount = PROGRESS_DATAWIDTH'(PROGRESS_TARGET);
   localparam logic [LEVEL_DATAWIDTH-1:0]    gameOverLevel = LEVEL_DATAWIDTH'(MAX_LEVEL + 1);
   localparam logic [PAUSE_DATAWIDTH-1:0]    pauseLast = PAUSE_DATAWIDTH'(PAUSE_CYCLES - 1);

   state_t                        stateReg, stateNext;
   logic [LEVEL_DATAWIDTH-1:0]    levelReg, levelNext;
   logic [PROGRESS_DATAWIDTH-1:0] countReg, countNext;
   logic [PAUSE_DATAWIDTH-1:0]    pauseReg, pauseNext;
   logic                          levelUpReg, levelUpNext;

   always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50) begin
      if (SC_LEVEL_PROGRESS_RESET_InHigh) begin
         stateReg   <= IDLE;
         levelReg   <= '0;
         countReg   <= '0;
         pauseReg   <= '0;
         levelUpReg <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         levelReg   <= levelNext;
         countReg   <= countNext;
         pauseReg   <= pauseNext;
         levelUpReg <= levelUpNext;
      end
   end

   always_comb begin
      stateNext   = stateReg;
      levelNext   = levelReg;
      countNext   = countReg;
      pauseNext   = pauseReg;
      levelUpNext = 1'b0;
      unique case (stateReg)
         IDLE: begin
            if (levelBus.SC_LEVEL_PROGRESS_Start_InHigh) begin
               stateNext   = PLAY;
               levelNext   = LEVEL_DATAWIDTH'(1);
               countNext   = '0;
               levelUpNext = 1'b1;
            end
         end
         PLAY: begin
            // Pause entry needs the count already at target, so a same-cycle advance cannot complete a level.
            if (countReg == targetCount) begin
               if (levelBus.SC_LEVEL_PROGRESS_LevelFinished_In) begin
                  stateNext = PAUSE;
                  pauseNext = '0;
               end
            end else if (levelBus.SC_LEVEL_PROGRESS_Advance_InHigh) begin
               countNext = countReg + 1'b1;
            end
         end
         PAUSE: begin
            if (levelBus.SC_LEVEL_PROGRESS_StartCount_In) begin
               if (pauseReg == pauseLast) begin
                  levelNext   = levelReg + 1'b1;
                  countNext   = '0;
                  pauseNext   = '0;
                  levelUpNext = 1'b1;
                  stateNext   = (levelReg + 1'b1 == gameOverLevel) ? DONE : PLAY;
               end else begin
                  pauseNext = pauseReg + 1'b1;
               end
            end
         end
         DONE: begin
            levelNext = gameOverLevel;
            countNext = '0;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign levelBus.SC_LEVEL_PROGRESS_CurrentLevel_Out     = levelReg;
   assign levelBus.SC_LEVEL_PROGRESS_LvlProgressCount_Out = countReg;
   assign levelBus.SC_LEVEL_PROGRESS_Paused_Out           = (stateReg != PLAY);
   assign levelBus.SC_LEVEL_PROGRESS_LevelUp_Out          = levelUpReg;
   assign levelBus.SC_LEVEL_PROGRESS_State_Out            = stateReg;

endmodule

// File: tb/tb_sc_level_progress.sv
// Bench for sc_level_progress: directed game walk-through plus random events,
// each cycle checked against a level/progress model of the game rules.
module tb_sc_level_progress;

   localparam int LW = 3;
   localparam int PW = 5;
   localparam int TARGET = 12;
   localparam int MAXL = 3;
   localparam int PAUSE_N = 4;

   logic SC_LEVEL_PROGRESS_CLOCK_50 = 1'b0;
   logic SC_LEVEL_PROGRESS_RESET_InHigh = 1'b1;

   sc_level_progress_if #(.LEVEL_DATAWIDTH(LW), .PROGRESS_DATAWIDTH(PW)) levelBus ();

   sc_level_progress #(
      .LEVEL_DATAWIDTH(LW), .PROGRESS_DATAWIDTH(PW), .PROGRESS_TARGET(TARGET),
      .MAX_LEVEL(MAXL), .PAUSE_CYCLES(PAUSE_N), .PAUSE_DATAWIDTH(3)
   ) dut (
      .SC_LEVEL_PROGRESS_CLOCK_50(SC_LEVEL_PROGRESS_CLOCK_50),
      .SC_LEVEL_PROGRESS_RESET_InHigh(SC_LEVEL_PROGRESS_RESET_InHigh),
      .levelBus(levelBus.slave)
   );

   // clock/reset block
   always #10 SC_LEVEL_PROGRESS_CLOCK_50 = ~SC_LEVEL_PROGRESS_CLOCK_50;

   int testsRun = 0;
   int testsFailed = 0;

   // game model: level 0 idle, MAXL+1 over, otherwise playing or between levels
   int  mLevel = 0;
   int  mCount = 0;
   int  mElapsed = 0;
   bit  mBetween = 0;
   bit  mLevelUp = 0;
   logic [LW-1:0] exp_q[$];

   task automatic check(input string tag, input int got, input int exp);
      testsRun++;
      if (got != exp) begin
         testsFailed++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit a, input bit lf, input bit sc);
      mLevelUp = 0;
      if (r) begin
         mLevel = 0; mCount = 0; mElapsed = 0; mBetween = 0;
      end else if (mLevel == 0) begin
         if (s) begin mLevel = 1; mCount = 0; mLevelUp = 1; end
      end else if (mLevel > MAXL) begin
         mCount = 0;
      end else if (mBetween) begin
         if (sc) mElapsed++;
         if (mElapsed == PAUSE_N) begin
            mBetween = 0; mLevel++; mCount = 0; mLevelUp = 1;
         end
      end else if (mCount == TARGET && lf) begin
         mBetween = 1; mElapsed = 0;
      end else if (a && mCount < TARGET) begin
         mCount++;
      end
      exp_q.push_back(LW'(mLevel));
   endtask

   // driver: one clock cycle with the given inputs, then check all outputs
   task automatic cycle(input bit r, input bit s, input bit a, input bit lf, input bit sc);
      logic [LW-1:0] expLevel;
      @(negedge SC_LEVEL_PROGRESS_CLOCK_50);
      SC_LEVEL_PROGRESS_RESET_InHigh = r;
      levelBus.SC_LEVEL_PROGRESS_Start_InHigh = s;
      levelBus.SC_LEVEL_PROGRESS_Advance_InHigh = a;
      levelBus.SC_LEVEL_PROGRESS_LevelFinished_In = lf;
      levelBus.SC_LEVEL_PROGRESS_StartCount_In = sc;
      @(posedge SC_LEVEL_PROGRESS_CLOCK_50);
      model_step(r, s, a, lf, sc);
      #1;
      expLevel = exp_q.pop_front();
      check("level", int'(levelBus.SC_LEVEL_PROGRESS_CurrentLevel_Out), int'(expLevel));
      check("count", int'(levelBus.SC_LEVEL_PROGRESS_LvlProgressCount_Out), mCount);
      check("paused", int'(levelBus.SC_LEVEL_PROGRESS_Paused_Out),
            int'(mLevel == 0 || mLevel > MAXL || mBetween));
      check("levelup", int'(levelBus.SC_LEVEL_PROGRESS_LevelUp_Out), int'(mLevelUp));
   endtask

   task automatic finish_level(input bit gappy);
      for (int i = 0; i < TARGET + 3; i++) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 1);
      if (gappy) begin
         cycle(0, 0, 1, 0, 1);
         for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 0);
      end
      for (int i = 0; i < PAUSE_N + 1; i++) cycle(0, 0, 1, 0, 1);
   endtask

   initial begin
      levelBus.SC_LEVEL_PROGRESS_Start_InHigh = 0;
      levelBus.SC_LEVEL_PROGRESS_Advance_InHigh = 0;
      levelBus.SC_LEVEL_PROGRESS_LevelFinished_In = 0;
      levelBus.SC_LEVEL_PROGRESS_StartCount_In = 0;

      // reset, idle ignores advance, start begins level 1
      cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 1, 1, 1);
      cycle(0, 0, 1, 1, 0);
      cycle(0, 1, 0, 0, 0);
      // early LevelFinished ignored, level 1 plain pause, level 2 stretched pause
      cycle(0, 0, 0, 1, 1);
      finish_level(0);
      finish_level(1);
      finish_level(0);
      // game over: everything ignored
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 1, 1);

      // reset during the level-2 pause
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      finish_level(0);
      for (int i = 0; i < TARGET; i++) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 1);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 1, 1, 0);

      // random events
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/sc_level_progress.md
Name: sc_level_progress

Overview:
- Producer side of the level-tracking interface. Generates the current-level number and the per-level progress count that the level state machine consumes.
- Consumes that state machine's LevelFinished and StartCount flags.
- Counts successful frog advances within a level and holds gameplay in a timed pause between levels.
- Advances the level number through 1..MAX_LEVEL, then reports end of game.

Parameters:
- LEVEL_DATAWIDTH, 3, width of current-level output.
- PROGRESS_DATAWIDTH, 5, width of progress count.
- PROGRESS_TARGET, 12, progress count that completes a level.
- MAX_LEVEL, 3, last playable level. Level value MAX_LEVEL+1 means game over.
- PAUSE_CYCLES, 50000000, length of the inter-level pause in qualified clock cycles (1 s at 50 MHz).
- PAUSE_DATAWIDTH, 26, width of the pause counter. Must hold PAUSE_CYCLES-1.

Ports:
- SC_LEVEL_PROGRESS_CLOCK_50  in  1  system clock, all logic on rising edge.
- SC_LEVEL_PROGRESS_RESET_InHigh  in  1  reset, synchronous, active-high.
- SC_LEVEL_PROGRESS_Start_InHigh  in  1  one-cycle start-game pulse.
- SC_LEVEL_PROGRESS_Advance_InHigh  in  1  one-cycle pulse per successful frog advance.
- SC_LEVEL_PROGRESS_LevelFinished_In  in  1  level-complete flag from the level state machine.
- SC_LEVEL_PROGRESS_StartCount_In  in  1  pause-timer enable from the level state machine.
- SC_LEVEL_PROGRESS_CurrentLevel_Out  out  LEVEL_DATAWIDTH  current level: 0 idle, 1..MAX_LEVEL playing, MAX_LEVEL+1 game over.
- SC_LEVEL_PROGRESS_LvlProgressCount_Out  out  PROGRESS_DATAWIDTH  advances completed in the current level.
- SC_LEVEL_PROGRESS_Paused_Out  out  1  high when gameplay is frozen (IDLE, PAUSE, DONE).
- SC_LEVEL_PROGRESS_LevelUp_Out  out  1  one-cycle pulse on every level increment.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous, active-high and overrides every other input in the same cycle.
- Reset values: state IDLE, CurrentLevel 0, LvlProgressCount 0, pause counter 0, Paused 1, LevelUp 0.
- All outputs are registered, or decoded from registered state only. No input-to-output combinational path.

State machine (registered state, 2 bits):
- IDLE:
  - Start=1 -> PLAY. CurrentLevel becomes 1 and LevelUp pulses in the same edge.
  - Advance pulses are ignored.
- PLAY:
  - Advance=1 and count<PROGRESS_TARGET -> count+1 on the next edge (latency 1).
  - Count saturates at PROGRESS_TARGET. Further Advance pulses are ignored.
  - Count==PROGRESS_TARGET and LevelFinished_In=1 -> PAUSE. Pause counter cleared on entry.
  - Count==PROGRESS_TARGET with LevelFinished_In=0 -> remain in PLAY, hold count.
  - LevelFinished_In=1 while count!=PROGRESS_TARGET is ignored.
  - Start is ignored.
- PAUSE:
  - Pause counter increments only in cycles where StartCount_In=1; it holds otherwise.
  - Counter==PAUSE_CYCLES-1 with StartCount_In=1 -> exit on that edge.
  - On exit: CurrentLevel+1, count cleared to 0, LevelUp=1 for exactly one cycle, aligned with the new level value.
  - Exit target: DONE if the new level == MAX_LEVEL+1, else PLAY.
  - Advance and Start are ignored.
  - With StartCount_In held high, the pause lasts exactly PAUSE_CYCLES cycles.
- DONE:
  - CurrentLevel held at MAX_LEVEL+1, count held at 0.
  - All inputs except reset are ignored. Only reset leaves DONE.

Arithmetic and outputs:
- Level arithmetic is unsigned and never wraps. The level increments only on PAUSE exit.
- Paused_Out = 1 in IDLE, PAUSE and DONE; 0 in PLAY.
- Simultaneous Advance and LevelFinished_In in the same cycle: Advance is evaluated against the current count. PAUSE entry requires the count to already equal the target.
- Reset mid-PAUSE or mid-PLAY: next cycle all registers return to their reset values. No LevelUp pulse is generated.

Test Plan (PAUSE_CYCLES=4, PROGRESS_TARGET=12, MAX_LEVEL=3 for simulation):
1. Reset, then Start pulse -> next cycle CurrentLevel=1, LevelUp=1 for one cycle, Paused=0, count=0.
2. 12 Advance pulses in PLAY -> count steps 1..12, one cycle after each pulse. 3 extra pulses -> count stays 12.
3. Count=12, LevelFinished_In=1, StartCount_In=1 held -> Paused=1 for 4 cycles. Then CurrentLevel=2, count=0, LevelUp pulse, Paused=0.
4. In PAUSE, drop StartCount_In low for 3 cycles mid-count -> pause lengthens to 7 cycles. Advance pulses during the pause leave count at 12.
5. Complete levels 1..3 -> after the third pause CurrentLevel=4 and Paused=1. Further Start, Advance and LevelFinished inputs change nothing.
6. Reset asserted during PAUSE of level 2 -> next cycle CurrentLevel=0, count=0, Paused=1, LevelUp=0. A Start pulse restarts at level 1.
